// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one single-port memory between the core's
// instruction (I) and data (D) ports. A winning request is latched, driven
// to memory until mem_ready or timeout, then answered with a one-cycle
// ready/error pulse on the granted port.
module elbeth_mem_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter bit          D_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  // instruction port
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_rw,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  output logic                i_error,
  // data port
  input  logic                d_en,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_rw,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_error,
  // memory port
  output logic                mem_enable,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rw,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                gnt_dport_q;   // 1 = data port owns the current access
  logic                last_dport_q;  // 1 = data port won the last grant
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_enable_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                i_ready_q, i_error_q, d_ready_q, d_error_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  logic                sel_dport;
  logic [ADDR_W-1:0]   addr_d;
  logic [STRB_W-1:0]   rw_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                timeout_hit;

  // Arbitration: D wins if alone, if it has priority, or if I won last time.
  always_comb begin
    sel_dport   = d_en && (!i_en || D_PRIORITY || !last_dport_q);
    addr_d      = sel_dport ? d_addr  : i_addr;
    rw_d        = sel_dport ? d_rw    : i_rw;
    wdata_d     = sel_dport ? d_wdata : i_wdata;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  end

  // Access FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_dport_q  <= 1'b0;
      last_dport_q <= 1'b1;
      cnt_q        <= '0;
      mem_enable_q <= 1'b0;
      addr_q       <= '0;
      rw_q         <= '0;
      wdata_q      <= '0;
      i_ready_q    <= 1'b0;
      i_error_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      d_error_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // Response outputs are single-cycle pulses by default.
      i_ready_q <= 1'b0;
      i_error_q <= 1'b0;
      d_ready_q <= 1'b0;
      d_error_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (i_en || d_en) begin
            gnt_dport_q  <= sel_dport;
            last_dport_q <= sel_dport;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            cnt_q        <= '0;
            mem_enable_q <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_enable_q <= 1'b0;
            state_q      <= RESP;
            if (gnt_dport_q) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= mem_rdata;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_enable_q <= 1'b0;
            state_q      <= RESP;
            if (gnt_dport_q) d_error_q <= 1'b1;
            else             i_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_enable = mem_enable_q;
  assign mem_addr   = addr_q;
  assign mem_rw     = rw_q;
  assign mem_wdata  = wdata_q;
  assign i_ready    = i_ready_q;
  assign i_error    = i_error_q;
  assign i_rdata    = i_rdata_q;
  assign d_ready    = d_ready_q;
  assign d_error    = d_error_q;
  assign d_rdata    = d_rdata_q;

endmodule
